// File: rtl/seq_alu_param.sv
// Sequential multi-cycle ALU: single-cycle logic/add/sub ops, radix-4 Booth signed
// multiply and (optionally) unsigned non-restoring divide.
// Optional feature: define SEQ_ALU_DIV_EN to build the divider (op 110); without it
// op 110 is reported as illegal like the reserved op 111.
module seq_alu_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               ovf,
    output logic               dz,
    output logic               illegal
);

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpXor = 3'b010;
    localparam logic [2:0] OpAdd = 3'b011;
    localparam logic [2:0] OpSub = 3'b100;
    localparam logic [2:0] OpMul = 3'b101;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [2:0] OpDiv = 3'b110;
`endif

    // Booth register layout: {acc[WIDTH+1:0], multiplier[WIDTH-1:0], guard}
    localparam int PW = 2 * WIDTH + 3;

    typedef enum logic [2:0] {
        StIdle, StLoad, StExec, StMulIt, StDivIt, StDivFix, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ovf_q, ovf_d, dz_q, dz_d, ill_q, ill_d;
    logic               accept;

    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH+1:0]   m1, m2, pp, hi_sum;
    logic [PW-1:0]      booth_tmp, booth_next;

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH+1:0]   rem_q, rem_d, shifted, d_ext, rem_step;
    logic [WIDTH-1:0]   quo_q, quo_d, quo_step;
`endif

    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;
    assign m1   = {{2{a_q[WIDTH-1]}}, a_q};
    assign m2   = {m1[WIDTH:0], 1'b0};

    // Booth radix-4 recoding of the low multiplier bits plus guard, then shift by 2
    always_comb begin
        pp = '0;
        case (prod_q[2:0])
            3'b001, 3'b010: pp = m1;
            3'b011:         pp = m2;
            3'b100:         pp = -m2;
            3'b101, 3'b110: pp = -m1;
            default:        pp = '0;
        endcase
        hi_sum     = prod_q[PW-1:WIDTH+1] + pp;
        booth_tmp  = {hi_sum, prod_q[WIDTH:0]};
        booth_next = {{2{booth_tmp[PW-1]}}, booth_tmp[PW-1:2]};
    end

`ifdef SEQ_ALU_DIV_EN
    // Non-restoring step: add or subtract divisor depending on partial remainder sign
    always_comb begin
        d_ext    = {2'b00, b_q};
        shifted  = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
        rem_step = rem_q[WIDTH+1] ? (shifted + d_ext) : (shifted - d_ext);
        quo_step = {quo_q[WIDTH-2:0], ~rem_step[WIDTH+1]};
    end
`endif

    // Next-state, iteration control and result/flag update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        ill_d    = ill_q;
        accept   = 1'b0;
`ifdef SEQ_ALU_DIV_EN
        rem_d    = rem_q;
        quo_d    = quo_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StLoad;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    ill_d   = 1'b0;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                prod_d  = {{(WIDTH + 2){1'b0}}, b_q, 1'b0};
`ifdef SEQ_ALU_DIV_EN
                rem_d   = '0;
                quo_d   = a_q;
`endif
                state_d = StExec;
            end
            StExec: begin
                state_d = StDone;
                case (op_q)
                    OpAnd: result_d = {{WIDTH{1'b0}}, a_q & b_q};
                    OpOr:  result_d = {{WIDTH{1'b0}}, a_q | b_q};
                    OpXor: result_d = {{WIDTH{1'b0}}, a_q ^ b_q};
                    OpAdd: begin
                        result_d = {{WIDTH{sum[WIDTH-1]}}, sum};
                        ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (sum[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OpSub: begin
                        result_d = {{WIDTH{diff[WIDTH-1]}}, diff};
                        ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                   (diff[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OpMul: state_d = StMulIt;
`ifdef SEQ_ALU_DIV_EN
                    OpDiv: begin
                        if (b_q == '0) begin
                            result_d = {a_q, {WIDTH{1'b1}}};
                            dz_d     = 1'b1;
                        end else begin
                            state_d = StDivIt;
                        end
                    end
`endif
                    default: begin
                        result_d = '0;
                        ill_d    = 1'b1;
                    end
                endcase
            end
            StMulIt: begin
                prod_d = booth_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH / 2 - 1)) begin
                    result_d = prod_d[2*WIDTH:1];
                    state_d  = StDone;
                end
            end
`ifdef SEQ_ALU_DIV_EN
            StDivIt: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StDivFix;
                end
            end
            StDivFix: begin
                // Quotient bits are already exact; only a negative remainder needs fixing
                rem_d    = rem_q[WIDTH+1] ? (rem_q + d_ext) : rem_q;
                result_d = {rem_d[WIDTH-1:0], quo_q};
                state_d  = StDone;
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            rem_q    <= '0;
            quo_q    <= '0;
`endif
        end else begin
            if (accept) begin
                op_q <= op;
                a_q  <= x;
                b_q  <= y;
            end
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            ill_q    <= ill_d;
`ifdef SEQ_ALU_DIV_EN
            rem_q    <= rem_d;
            quo_q    <= quo_d;
`endif
        end
    end

    assign busy    = (state_q != StIdle) && (state_q != StDone);
    assign done    = (state_q == StDone);
    assign result  = result_q;
    assign ovf     = ovf_q;
    assign dz      = dz_q;
    assign illegal = ill_q;

endmodule

// File: tb/tb_seq_alu_param.sv
// Directed self-checking bench for seq_alu_param (WIDTH=8) with an expected-result queue.
module tb_seq_alu_param;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [7:0]  x, y;
    logic        busy, done, ovf, dz, illegal;
    logic [15:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic        o, d, i;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seq_alu_param #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .x       (x),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .dz      (dz),
        .illegal (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one operation, then wait (bounded) for done and compare against the queue head
    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] er, input logic eo,
                          input logic ed, input logic ei, input int elat, input bit poke);
        exp_t e;
        int   lat;
        int   extra;
        e = '{tag: tag, res: er, o: eo, d: ed, i: ei, lat: elat};
        sb.push_back(e);
        @(negedge clk);
        op = o; x = a; y = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x = 8'($urandom);
        y = 8'($urandom);
        op = 3'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (poke && lat == 2) begin
                start = 1'b1;
                op    = 3'b011;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        e = sb.pop_front();
        check({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({e.tag, "_result"}, 32'(result), 32'(e.res));
        check({e.tag, "_flags"}, {29'd0, ovf, dz, illegal}, {29'd0, e.o, e.d, e.i});
        if (poke) begin
            extra = 0;
            repeat (10) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            check({e.tag, "_extra_done"}, 32'(extra), 32'd0);
            check({e.tag, "_result_kept"}, 32'(result), 32'(e.res));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; x = '0; y = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {26'd0, busy, done, ovf, dz, illegal, 1'b0}, 32'd0);
        check("reset_result", 32'(result), 32'd0);
        reset = 1'b0;

        run_op("and", 3'b000, 8'hF0, 8'h3C, 16'h0030, 0, 0, 0, 2, 0);
        run_op("or",  3'b001, 8'hA0, 8'h05, 16'h00A5, 0, 0, 0, 2, 0);
        run_op("xor", 3'b010, 8'hFF, 8'h0F, 16'h00F0, 0, 0, 0, 2, 0);
        run_op("add_ovf", 3'b011, 8'h7F, 8'h01, 16'hFF80, 1, 0, 0, 2, 0);
        // Flags and result hold after done until the next acceptance
        repeat (3) @(negedge clk);
        check("add_ovf_held", {31'd0, ovf}, 32'd1);
        check("add_result_held", 32'(result), 32'hFF80);
        run_op("add_neg", 3'b011, 8'hFE, 8'hFD, 16'hFFFB, 0, 0, 0, 2, 0);
        run_op("sub_ovf", 3'b100, 8'h80, 8'h01, 16'h007F, 1, 0, 0, 2, 0);
        run_op("sub", 3'b100, 8'h05, 8'h07, 16'hFFFE, 0, 0, 0, 2, 0);
        run_op("mul_neg", 3'b101, 8'hFD, 8'h05, 16'hFFF1, 0, 0, 0, 6, 0);
        run_op("mul_min", 3'b101, 8'h80, 8'h80, 16'h4000, 0, 0, 0, 6, 0);
        run_op("mul_busy_start", 3'b101, 8'h7F, 8'h81, 16'hC0FF, 0, 0, 0, 6, 1);
`ifdef SEQ_ALU_DIV_EN
        run_op("div", 3'b110, 8'd100, 8'd7, 16'h020E, 0, 0, 0, 11, 0);
        run_op("div_zero", 3'b110, 8'h55, 8'h00, 16'h55FF, 0, 1, 0, 2, 0);
        run_op("div_max", 3'b110, 8'hFF, 8'h10, 16'h0F0F, 0, 0, 0, 11, 0);
`else
        run_op("div_off", 3'b110, 8'd100, 8'd7, 16'h0000, 0, 0, 1, 2, 0);
        run_op("div_off_zero", 3'b110, 8'h55, 8'h00, 16'h0000, 0, 0, 1, 2, 0);
`endif
        run_op("reserved", 3'b111, 8'h12, 8'h34, 16'h0000, 0, 0, 1, 2, 0);
        run_op("mul_pre_reset", 3'b101, 8'h7F, 8'h7F, 16'h3F01, 0, 0, 0, 6, 0);

        // Abort a multiply mid-iteration with reset
        @(negedge clk);
        op = 3'b101; x = 8'hFD; y = 8'h05; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_outputs", {26'd0, busy, done, ovf, dz, illegal, 1'b0}, 32'd0);
        check("midreset_result", 32'(result), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (8) begin
                @(negedge clk);
                if (done === 1'b1) seen++;
            end
            check("midreset_no_done", 32'(seen), 32'd0);
        end
        run_op("xor_after_reset", 3'b010, 8'hF0, 8'h3C, 16'h00CC, 0, 0, 0, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_alu_param.md
SEQ_ALU_PARAM -- requirements
Module: seq_alu_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; even, >= 4.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-006 SHALL have port op  input  3  000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110 DIV, 111 reserved.
REQ-007 SHALL have ports x, y  input  WIDTH each  operands, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port result  output  2*WIDTH  {high, low} word, held until next acceptance.
REQ-011 SHALL have port ovf  output  1  signed overflow of ADD/SUB.
REQ-012 SHALL have port dz  output  1  divide-by-zero flag.
REQ-013 SHALL have port illegal  output  1  reserved or compiled-out op requested.

Function
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored, without queuing.
REQ-015 SHALL implement states IDLE, LOAD, EXEC, MUL_IT, DIV_IT, DIV_FIX, DONE; DONE always returns to IDLE.
REQ-016 Logic ops SHALL give result = {WIDTH zeros, x op y}; ovf=0; latency 2 cycles from acceptance edge to done.
REQ-017 ADD/SUB SHALL give two's-complement low word, high word = sign extension of low word, ovf per signed overflow; latency 2.
REQ-018 MUL SHALL be signed radix-4 Booth, WIDTH/2 iterations in MUL_IT, each examining 3 multiplier bits with a guard bit; full 2*WIDTH signed product; latency WIDTH/2+2.
REQ-019 DIV SHALL be unsigned non-restoring, WIDTH iterations in DIV_IT plus one DIV_FIX remainder-correction cycle; result = {remainder, quotient}; latency WIDTH+3.
REQ-020 DIV with y=0 SHALL skip iteration, assert dz, give quotient all ones, remainder = x; latency 2.
REQ-021 Reserved op SHALL assert illegal, give result 0; latency 2.
REQ-022 ovf, dz, illegal SHALL update with done and hold until next acceptance; cleared on acceptance.
REQ-023 Iteration counter SHALL clear in LOAD, increment once per iteration, never wrap during an operation.
REQ-024 Operand changes after acceptance SHALL not affect the result.
REQ-025 start asserted in the DONE cycle SHALL be ignored; it is accepted on the following IDLE cycle if still high.

Reset
REQ-026 reset SHALL force IDLE, busy=0, done=0, result=0, ovf=0, dz=0, illegal=0, counter=0, asynchronously, at any state.
REQ-027 Reset mid-operation SHALL abort the operation without a done pulse; first start after release SHALL be accepted normally.

Configuration
REQ-028 Macro SEQ_ALU_DIV_EN defined SHALL include the divider datapath and DIV_IT/DIV_FIX states per REQ-019/020.
REQ-029 Macro SEQ_ALU_DIV_EN undefined SHALL remove divider logic; op 110 SHALL behave as reserved (illegal=1, result 0, latency 2, dz stays 0).

Verification (WIDTH=8, SEQ_ALU_DIV_EN defined unless stated)
REQ-030 ADD x=8'h7F y=8'h01 -> done 2 cycles after acceptance, result 16'hFF80, ovf=1.
REQ-031 MUL x=8'hFD (-3) y=8'h05 -> done at cycle 6, result 16'hFFF1; MUL 8'h80*8'h80 -> 16'h4000.
REQ-032 DIV x=100 y=7 -> done at cycle 11, result 16'h020E, dz=0; DIV x=8'h55 y=0 -> 16'h55FF, dz=1, latency 2.
REQ-033 Start with op=011 pulsed while MUL busy -> ignored, only MUL done pulse, MUL result unchanged.
REQ-034 reset asserted at MUL iteration 2 -> all outputs 0 immediately, no done; next XOR 8'hF0^8'h3C -> 16'h00CC.
REQ-035 SEQ_ALU_DIV_EN undefined, op=110 x=100 y=7 -> result 0, illegal=1, dz=0, latency 2.
